// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the E-stage multiply/divide unit.
//   mdu_op_e        MDU operation codes as carried in the E-stage register
//   *_CYCLES_DEF    default busy lengths for multiply and divide
//   is_start(op)    true for ops that launch a multi-cycle mult/div
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MFHI  = 4'd5,
    OP_MFLO  = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  function automatic logic is_start(input mdu_op_e op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_calc.sv
// mdu_calc: combinational arithmetic core of the MDU.
//   op        latched MDU op (only MULT/MULTU/DIV/DIVU produce a result)
//   a, b      latched rs / rt operands
//   result    {hi, lo}: 64-bit product, or {remainder, quotient}
//   div_zero  divide op with a zero divisor (result is then meaningless)
module mdu_calc
  import mdu_pkg::*;
(
  input  mdu_op_e     op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] mag_a;
  logic        [31:0] mag_b;
  logic        [31:0] dvd;
  logic        [31:0] dvs;
  logic        [31:0] q_u;
  logic        [31:0] r_u;
  logic        [31:0] q_fix;
  logic        [31:0] r_fix;
  logic               is_sdiv;

  assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes and fixes signs afterwards, so that
  // 0x80000000 / -1 falls out as 0x80000000 rem 0 without a special case.
  assign mag_a   = a[31] ? (~a + 32'd1) : a;
  assign mag_b   = b[31] ? (~b + 32'd1) : b;
  assign is_sdiv = (op == OP_DIV);

  always_comb begin
    dvd = is_sdiv ? mag_a : a;
    dvs = is_sdiv ? mag_b : b;
    q_u = '0;
    r_u = '0;
    if (dvs != '0) begin
      q_u = dvd / dvs;
      r_u = dvd % dvs;
    end
    q_fix = (is_sdiv && (a[31] ^ b[31])) ? (~q_u + 32'd1) : q_u;
    r_fix = (is_sdiv && a[31])           ? (~r_u + 32'd1) : r_u;
  end

  always_comb begin
    result   = '0;
    div_zero = 1'b0;
    unique case (op)
      OP_MULT:          result = $unsigned(prod_s);
      OP_MULTU:         result = prod_u;
      OP_DIV, OP_DIVU: begin
        result   = {r_fix, q_fix};
        div_zero = (b == '0);
      end
      default:          result = '0;
    endcase
  end

endmodule

// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit with HI/LO registers.
//   clk, reset  clock and synchronous active-high reset
//   MDUOpE      E-stage MDU op code (mdu_pkg::mdu_op_e encoding)
//   RD1E, RD2E  forwarded rs / rt values
//   MDUUseD     D-stage instruction is an MDU op
//   BusyE       a mult/div is in flight
//   StallMD     combinational stall request to the hazard unit
//   HILOOutE    HI for MFHI, LO for MFLO, else 0
//   DivZeroE    (only with MDU_DIVZERO_FLAG_EN) one-cycle pulse after a
//               divide by zero completes
module mdu_e
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDUOpE,
  input  logic [31:0] RD1E,
  input  logic [31:0] RD2E,
  input  logic        MDUUseD,
  output logic        BusyE,
  output logic        StallMD,
  output logic [31:0] HILOOutE
`ifdef MDU_DIVZERO_FLAG_EN
  ,
  output logic        DivZeroE
`endif
);

  mdu_op_e     op_e;
  mdu_op_e     op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [3:0]  cnt_q;
  logic [63:0] calc_result;
  logic        calc_div_zero;
  logic        start;
  logic        finish;

  assign op_e = mdu_op_e'(MDUOpE);

  mdu_calc u_calc (
    .op       (op_q),
    .a        (a_q),
    .b        (b_q),
    .result   (calc_result),
    .div_zero (calc_div_zero)
  );

  always_comb begin
    BusyE    = (cnt_q != '0);
    start    = is_start(op_e) && !BusyE;
    finish   = (cnt_q == 4'd1);
    StallMD  = MDUUseD && (BusyE || is_start(op_e));
    HILOOutE = '0;
    if (op_e == OP_MFHI) HILOOutE = hi_q;
    if (op_e == OP_MFLO) HILOOutE = lo_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q  <= OP_NONE;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (start) begin
        op_q  <= op_e;
        a_q   <= RD1E;
        b_q   <= RD2E;
        cnt_q <= ((op_e == OP_MULT) || (op_e == OP_MULTU)) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      end else if (BusyE) begin
        cnt_q <= cnt_q - 4'd1;
        if (finish && !calc_div_zero) begin
          hi_q <= calc_result[63:32];
          lo_q <= calc_result[31:0];
        end
      end
      if (!BusyE && op_e == OP_MTHI) hi_q <= RD1E;
      if (!BusyE && op_e == OP_MTLO) lo_q <= RD1E;
    end
  end

`ifdef MDU_DIVZERO_FLAG_EN
  always_ff @(posedge clk) begin
    if (reset) DivZeroE <= 1'b0;
    else       DivZeroE <= BusyE && finish && calc_div_zero;
  end
`endif

endmodule

// File: tb/tb_mdu_e.sv
module tb_mdu_e;
  import mdu_pkg::*;

  typedef struct {
    string       name;
    logic        busy;
    logic        stall;
    logic [31:0] hilo;
    logic        dz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  op = 4'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        use_d = 1'b0;
  logic        busy;
  logic        stall;
  logic [31:0] hilo;
`ifdef MDU_DIVZERO_FLAG_EN
  logic        dz;
`endif

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  mdu_e #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (rst),
    .MDUOpE   (op),
    .RD1E     (a),
    .RD2E     (b),
    .MDUUseD  (use_d),
    .BusyE    (busy),
    .StallMD  (stall),
    .HILOOutE (hilo)
`ifdef MDU_DIVZERO_FLAG_EN
    ,
    .DivZeroE (dz)
`endif
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check({e.name, ".busy"},  {31'd0, busy},  {31'd0, e.busy});
      check({e.name, ".stall"}, {31'd0, stall}, {31'd0, e.stall});
      check({e.name, ".hilo"},  hilo,           e.hilo);
`ifdef MDU_DIVZERO_FLAG_EN
      check({e.name, ".dz"},    {31'd0, dz},    {31'd0, e.dz});
`endif
    end
  end

  task automatic step(input string nm, input mdu_op_e o, input logic [31:0] ra, input logic [31:0] rb,
                      input logic u, input logic r, input logic chk,
                      input logic eb, input logic es, input logic [31:0] eh, input logic edz);
    exp_t e;
    @(posedge clk);
    #1;
    op    = o;
    a     = ra;
    b     = rb;
    use_d = u;
    rst   = r;
    if (chk) begin
      e.name  = nm;
      e.busy  = eb;
      e.stall = es;
      e.hilo  = eh;
      e.dz    = edz;
      sb.push_back(e);
    end
  endtask

  // Busy cycles: E holds a bubble, live operands carry junk that must not leak.
  task automatic busy_run(input string nm, input int n, input logic u);
    for (int i = 0; i < n; i++)
      step(nm, OP_NONE, 32'hA5A5A5A5, 32'h5A5A5A5A, u, 1'b0, 1'b1, 1'b1, u, 32'h0, 1'b0);
  endtask

  initial begin
    step("rst", OP_NONE, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("rst", OP_NONE, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    step("reset_state", OP_NONE, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
    step("reset_hi",    OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
    step("reset_lo",    OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);

    step("mult_start", OP_MULT, 32'hFFFFFFFE, 32'd3, 0, 0, 1, 0, 0, 32'h0, 0);
    busy_run("mult_busy", 5, 0);
    step("mult_hi", OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 0);
    step("mult_lo", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFA, 0);

    step("multu_start", OP_MULTU, 32'hFFFFFFFE, 32'd3, 0, 0, 1, 0, 0, 32'h0, 0);
    busy_run("multu_busy", 1, 0);
    step("multu_mthi_ign", OP_MTHI, 32'h0000DEAD, 0, 0, 0, 1, 1, 0, 32'h0, 0);
    busy_run("multu_busy", 3, 0);
    step("multu_hi", OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'h00000002, 0);
    step("multu_lo", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFA, 0);

    step("div_start", OP_DIV, 32'hFFFFFFF9, 32'd2, 0, 0, 1, 0, 0, 32'h0, 0);
    busy_run("div_busy", 10, 0);
    step("div_lo", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFD, 0);
    step("div_hi", OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFF, 0);

    step("ovf_start", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 32'h0, 0);
    busy_run("ovf_busy", 10, 0);
    step("ovf_lo", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'h80000000, 0);
    step("ovf_hi", OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'h00000000, 0);

    step("mthi",    OP_MTHI, 32'h1234, 32'hFFFF, 0, 0, 1, 0, 0, 32'h0, 0);
    step("mtlo",    OP_MTLO, 32'h5678, 32'hFFFF, 0, 0, 1, 0, 0, 32'h0, 0);
    step("mthi_rd", OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'h1234, 0);
    step("mtlo_rd", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'h5678, 0);

    step("divz_start", OP_DIVU, 32'd5, 32'd0, 0, 0, 1, 0, 0, 32'h0, 0);
    busy_run("divz_busy", 10, 0);
    step("divz_hi", OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'h1234, 1);
    step("divz_lo", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'h5678, 0);

    step("stall_start", OP_MULT, 32'd7, 32'd6, 1, 0, 1, 0, 1, 32'h0, 0);
    busy_run("stall_busy", 5, 1);
    step("stall_release", OP_NONE, 0, 0, 1, 0, 1, 0, 0, 32'h0, 0);
    step("stall_mflo", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'd42, 0);
    step("stall_mfhi", OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'd0, 0);

    step("rdiv_start", OP_DIV, 32'd100, 32'd7, 0, 0, 1, 0, 0, 32'h0, 0);
    busy_run("rdiv_busy", 2, 0);
    step("rdiv_cyc3", OP_NONE, 0, 0, 0, 1, 1, 1, 0, 32'h0, 0);
    step("post_rst_hi", OP_MFHI, 0, 0, 1, 0, 1, 0, 0, 32'h0, 0);
    step("post_rst_lo", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);
    step("multu2_start", OP_MULTU, 32'd2, 32'd3, 0, 0, 1, 0, 0, 32'h0, 0);
    busy_run("multu2_busy", 5, 0);
    step("multu2_lo", OP_MFLO, 0, 0, 0, 0, 1, 0, 0, 32'd6, 0);
    step("multu2_hi", OP_MFHI, 0, 0, 0, 0, 1, 0, 0, 32'd0, 0);
    step("tail", OP_NONE, 0, 0, 0, 0, 1, 0, 0, 32'h0, 0);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
